// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames 4-byte commands (header, cmd, data, checksum) from the
// UART receive strobe, executes LED write/read, and returns ACK/NAK responses
// to the UART transmitter.
//
// Transmit handshake: a byte moves on any cycle where tx_vld=1 and tx_rdy=1.
// Once tx_vld is raised, it and tx_data hold steady until that transfer
// happens. After the last byte of a response, tx_vld is low for at least one
// cycle.
module uart_cmd_ctrl #(
   parameter logic [7:0]  HEAD    = 8'h55,
   parameter int unsigned TIMEOUT = 156250,
   parameter logic [7:0]  ACK     = 8'hAA,
   parameter logic [7:0]  NAK     = 8'hEE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_vld,
   output logic [7:0] tx_data,
   output logic       tx_vld,
   input  logic       tx_rdy,
   output logic [7:0] led,
   output logic       frm_err
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_CMD = 3'd1,
      GET_DAT = 3'd2,
      GET_CHK = 3'd3,
      EXEC    = 3'd4,
      RSP0    = 3'd5,
      RSP1    = 3'd6
   } state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [7:0]     cmd_q, cmd_n;
   logic [7:0]     dat_q, dat_n;
   logic [7:0]     chk_q, chk_n;
   logic [7:0]     led_q, led_n;
   logic           tx_vld_q, tx_vld_n;
   logic [7:0]     tx_data_q, tx_data_n;
   logic [7:0]     byte1_q, byte1_n;   // second response byte, if any
   logic           two_q, two_n;       // response has a second byte
   logic           frm_err_q, frm_err_n;

   // State and every output register; reset abandons any frame or response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_q     <= 8'h00;
         dat_q     <= 8'h00;
         chk_q     <= 8'h00;
         led_q     <= 8'h00;
         tx_vld_q  <= 1'b0;
         tx_data_q <= 8'h00;
         byte1_q   <= 8'h00;
         two_q     <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cmd_q     <= cmd_n;
         dat_q     <= dat_n;
         chk_q     <= chk_n;
         led_q     <= led_n;
         tx_vld_q  <= tx_vld_n;
         tx_data_q <= tx_data_n;
         byte1_q   <= byte1_n;
         two_q     <= two_n;
         frm_err_q <= frm_err_n;
      end
   end

   // Next-state, byte capture, timeout, command execution and response sequencing.
   always_comb begin
      state_n   = state;
      cnt_n     = '0;
      cmd_n     = cmd_q;
      dat_n     = dat_q;
      chk_n     = chk_q;
      led_n     = led_q;
      tx_vld_n  = tx_vld_q;
      tx_data_n = tx_data_q;
      byte1_n   = byte1_q;
      two_n     = two_q;
      frm_err_n = 1'b0;

      // The counter only runs while waiting for the next byte of a frame.
      if ((state == GET_CMD || state == GET_DAT || state == GET_CHK) && !rx_vld)
         cnt_n = cnt + CW'(1);

      case (state)
         IDLE: begin
            if (rx_vld && rx_data == HEAD)
               state_n = GET_CMD;
         end
         GET_CMD: begin
            if (rx_vld) begin
               cmd_n   = rx_data;
               state_n = GET_DAT;
            end else if (cnt == CNT_LAST) begin
               frm_err_n = 1'b1;
               cnt_n     = '0;
               state_n   = IDLE;
            end
         end
         GET_DAT: begin
            if (rx_vld) begin
               dat_n   = rx_data;
               state_n = GET_CHK;
            end else if (cnt == CNT_LAST) begin
               frm_err_n = 1'b1;
               cnt_n     = '0;
               state_n   = IDLE;
            end
         end
         GET_CHK: begin
            if (rx_vld) begin
               chk_n   = rx_data;
               state_n = EXEC;
            end else if (cnt == CNT_LAST) begin
               frm_err_n = 1'b1;
               cnt_n     = '0;
               state_n   = IDLE;
            end
         end
         EXEC: begin
            if (chk_q != (cmd_q ^ dat_q)) begin
               frm_err_n = 1'b1;
               state_n   = IDLE;
            end else if (cmd_q == CMD_WR) begin
               led_n     = dat_q;
               tx_vld_n  = 1'b1;
               tx_data_n = ACK;
               byte1_n   = dat_q;
               two_n     = 1'b1;
               state_n   = RSP0;
            end else if (cmd_q == CMD_RD) begin
               // Report the LED value as it stood before this frame.
               tx_vld_n  = 1'b1;
               tx_data_n = ACK;
               byte1_n   = led_q;
               two_n     = 1'b1;
               state_n   = RSP0;
            end else begin
               frm_err_n = 1'b1;
               tx_vld_n  = 1'b1;
               tx_data_n = NAK;
               two_n     = 1'b0;
               state_n   = RSP0;
            end
         end
         RSP0: begin
            if (tx_vld_q && tx_rdy) begin
               if (two_q) begin
                  tx_data_n = byte1_q;
                  state_n   = RSP1;
               end else begin
                  tx_vld_n = 1'b0;
                  state_n  = IDLE;
               end
            end
         end
         RSP1: begin
            if (tx_vld_q && tx_rdy) begin
               tx_vld_n = 1'b0;
               state_n  = IDLE;
            end
         end
         default: begin
            state_n  = IDLE;
            tx_vld_n = 1'b0;
         end
      endcase
   end

   assign tx_data = tx_data_q;
   assign tx_vld  = tx_vld_q;
   assign led     = led_q;
   assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized frames against a frame-level
// reference model (expected response bytes, error pulses, LED value).
module tb_uart_cmd_ctrl;

   localparam int TO = 40;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic [7:0] tx_data;
   logic       tx_vld;
   logic       tx_rdy;
   logic [7:0] led;
   logic       frm_err;

   uart_cmd_ctrl #(.TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_data (rx_data),
      .rx_vld  (rx_vld),
      .tx_data (tx_data),
      .tx_vld  (tx_vld),
      .tx_rdy  (tx_rdy),
      .led     (led),
      .frm_err (frm_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [7:0] act_q[$];
   int         acc_cyc[$];
   int         tests = 0;
   int         fails = 0;
   int         err_seen = 0;
   int         err_base = 0;
   int         rise_cyc = -1;
   int         chk_cyc = 0;
   logic [7:0] led_at_rise = 8'h00;
   logic [7:0] model_led = 8'h00;
   int         exp_err = 0;
   bit         rdy_rand = 0;

   logic       prev_vld = 1'b0;
   logic       prev_rdy = 1'b0;
   logic       prev_err = 1'b0;
   logic [7:0] prev_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled mid-cycle: records transfers, error pulses and
   // checks that a pending byte is held until it is taken.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
         prev_rdy = 1'b0;
         prev_err = 1'b0;
      end else begin
         if (prev_vld && !prev_rdy) begin
            tests++;
            assert (tx_vld === 1'b1 && tx_data === prev_data) else begin
               fails++;
               $error("FAIL hold: observed vld=%b data=%h expected vld=1 data=%h",
                      tx_vld, tx_data, prev_data);
            end
         end
         if (frm_err === 1'b1) begin
            err_seen++;
            tests++;
            assert (prev_err === 1'b0) else begin
               fails++;
               $error("FAIL err_width: observed frm_err high 2 cycles expected 1");
            end
         end
         if (tx_vld === 1'b1 && prev_vld === 1'b0) begin
            rise_cyc    = cyc;
            led_at_rise = led;
         end
         if (tx_vld === 1'b1 && tx_rdy === 1'b1) begin
            act_q.push_back(tx_data);
            acc_cyc.push_back(cyc);
         end
         prev_vld  = tx_vld;
         prev_rdy  = tx_rdy;
         prev_err  = frm_err;
         prev_data = tx_data;
      end
   end

   // ---------------- reference model ----------------
   // Frame-level rule set: checksum first, then write / read / unknown.
   task automatic model_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
      if (k != (c ^ d)) begin
         exp_err = 1;
      end else if (c == 8'h01) begin
         exp_q.push_back(8'hAA);
         exp_q.push_back(d);
         model_led = d;
      end else if (c == 8'h02) begin
         exp_q.push_back(8'hAA);
         exp_q.push_back(model_led);
      end else begin
         exp_err = 1;
         exp_q.push_back(8'hEE);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) tx_rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_vld  = 1'b1;
      rx_data = b;
      tick();
      rx_vld  = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic begin_frame();
      exp_q.delete();
      act_q.delete();
      acc_cyc.delete();
      err_base = err_seen;
      rise_cyc = -1;
      exp_err  = 0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] d,
                             input logic [7:0] k, input int gap);
      send_byte(8'h55);
      idle(gap);
      send_byte(c);
      idle(gap);
      send_byte(d);
      idle(gap);
      chk_cyc = cyc;
      send_byte(k);
   endtask

   task automatic finish_frame(input string tag);
      int budget = 400;
      while (act_q.size() < exp_q.size() && budget > 0) begin
         tick();
         budget--;
      end
      idle(4);
      check({tag, "_nbytes"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < act_q.size()) check({tag, "_byte"}, act_q[i], exp_q[i]);
      check({tag, "_vld_low"}, tx_vld, 1'b0);
      check({tag, "_errs"}, err_seen - err_base, exp_err);
      check({tag, "_led"}, led, model_led);
      if (exp_q.size() > 0) begin
         check({tag, "_latency"}, rise_cyc - chk_cyc, 2);
         check({tag, "_led_at_rsp"}, led_at_rise, model_led);
      end
   endtask

   task automatic do_frame(input string tag, input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] k, input int gap);
      begin_frame();
      model_frame(c, d, k);
      send_frame(c, d, k, gap);
      finish_frame(tag);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] c, d, k, b;
      int         n;

      rst_n   = 1'b0;
      rx_vld  = 1'b0;
      rx_data = 8'h00;
      tx_rdy  = 1'b1;
      idle(3);
      check("rst_tx_vld", tx_vld, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_led", led, 8'h00);
      check("rst_frm_err", frm_err, 1'b0);
      rst_n = 1'b1;
      idle(2);

      // Non-header bytes in IDLE are ignored silently.
      begin_frame();
      send_byte(8'h01);
      send_byte(8'h3C);
      idle(3);
      send_byte(8'hA5);
      finish_frame("idle_junk");

      do_frame("write", 8'h01, 8'h3C, 8'h3D, 0);
      do_frame("read", 8'h02, 8'h00, 8'h02, 1);
      do_frame("bad_chk", 8'h01, 8'hF0, 8'h00, 0);
      do_frame("bad_cmd", 8'h07, 8'h11, 8'h16, 2);

      // Timeout after two bytes, then a clean write.
      begin_frame();
      exp_err = 1;
      send_byte(8'h55);
      send_byte(8'h01);
      idle(TO + 5);
      finish_frame("timeout");
      do_frame("after_to", 8'h01, 8'h81, 8'h80, 0);

      // Byte arriving on the last allowed cycle still counts.
      do_frame("gap_edge", 8'h02, 8'h00, 8'h02, TO - 1);

      // One cycle later is a timeout; the late byte lands in IDLE.
      begin_frame();
      exp_err = 1;
      send_byte(8'h55);
      idle(TO);
      send_byte(8'h01);
      idle(5);
      finish_frame("gap_late");

      // Backpressure with a would-be bad frame arriving during the response.
      begin_frame();
      model_frame(8'h01, 8'h3C, 8'h3D);
      tx_rdy = 1'b0;
      send_frame(8'h01, 8'h3C, 8'h3D, 0);
      idle(2);
      for (int i = 0; i < 50; i++) begin
         if (i == 5)       send_byte(8'h55);
         else if (i == 8)  send_byte(8'h01);
         else if (i == 11) send_byte(8'hF0);
         else if (i == 14) send_byte(8'h00);
         else              tick();
      end
      check("bp_vld", tx_vld, 1'b1);
      check("bp_data", tx_data, 8'hAA);
      tx_rdy = 1'b1;
      finish_frame("bp");
      if (acc_cyc.size() >= 2) check("bp_back2back", acc_cyc[1] - acc_cyc[0], 1);
      else check("bp_accepts", acc_cyc.size(), 2);

      // Randomized frames with random backpressure.
      rdy_rand = 1;
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) begin
            b = 8'($urandom);
            if (b == 8'h55) b = 8'h00;
            send_byte(b);
         end
         if ($urandom_range(0, 7) == 0) begin
            begin_frame();
            exp_err = 1;
            send_byte(8'h55);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) send_byte(8'($urandom));
            idle(TO + 3);
            finish_frame("rnd_to");
         end else begin
            case ($urandom_range(0, 3))
               0, 1:    c = 8'h01;
               2:       c = 8'h02;
               default: c = 8'($urandom);
            endcase
            d = 8'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ d);
            do_frame("rnd", c, d, k, $urandom_range(0, 3));
         end
      end
      rdy_rand = 0;
      tx_rdy   = 1'b1;

      // Reset in the middle of a held response abandons it.
      begin_frame();
      tx_rdy = 1'b0;
      send_frame(8'h01, 8'h5A, 8'h5B, 0);
      idle(4);
      rst_n = 1'b0;
      #1;
      check("midrst_vld", tx_vld, 1'b0);
      check("midrst_data", tx_data, 8'h00);
      check("midrst_led", led, 8'h00);
      check("midrst_err", frm_err, 1'b0);
      idle(2);
      rst_n     = 1'b1;
      tx_rdy    = 1'b1;
      model_led = 8'h00;
      idle(2);
      do_frame("post_rst_rd", 8'h02, 8'h33, 8'h31, 0);
      do_frame("post_rst_wr", 8'h01, 8'hC3, 8'hC2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver byte output and the board LED register.
- Parses 4-byte frames from the receive path: header, command, data, checksum.
- Executes LED write or read commands.
- Schedules one- or two-byte responses to the UART transmitter over a valid/ready handshake, and enforces an inter-byte timeout.

Parameters:
- HEAD, 8'h55, frame header byte.
- TIMEOUT, 156250, max clk cycles between consecutive frame bytes (3 byte times at 9600 baud, 50 MHz).
- ACK, 8'hAA, positive response byte.
- NAK, 8'hEE, negative response byte.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from UART receiver; valid only when rx_vld=1.
- rx_vld  in  1  one-cycle strobe, one per received byte.
- tx_data  out  8  byte to UART transmitter.
- tx_vld  out  1  transmit request; held until accepted.
- tx_rdy  in  1  transmitter ready; a byte transfers on a cycle with tx_vld=1 and tx_rdy=1.
- led  out  8  LED register.
- frm_err  out  1  one-cycle pulse on any dropped frame (checksum, timeout, bad cmd).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, led=8'h00, tx_vld=0, tx_data=8'h00, frm_err=0, timeout counter=0, cmd/data/chk registers=0.
- States: IDLE, GET_CMD, GET_DAT, GET_CHK, EXEC, RSP0, RSP1. All outputs are registered.
- IDLE: on rx_vld with rx_data==HEAD -> GET_CMD. Any other byte is ignored, with no frm_err.
- GET_CMD: on rx_vld, latch cmd -> GET_DAT.
- GET_DAT: on rx_vld, latch data -> GET_CHK.
- GET_CHK: on rx_vld, latch chk -> EXEC.
- Timeout:
  - Counter clears on every rx_vld and while in IDLE, and increments each cycle in GET_CMD/GET_DAT/GET_CHK.
  - On reaching TIMEOUT-1 without rx_vld: pulse frm_err, go to IDLE, send no response.
  - If rx_vld arrives on the same cycle as expiry, the byte wins; no timeout.
- EXEC (one cycle), checks in order:
  - chk != (cmd ^ data): frm_err=1, -> IDLE, no response (silent drop).
  - cmd==8'h01 (write): led<=data on the cycle after EXEC; queue ACK then data echo; -> RSP0.
  - cmd==8'h02 (read): data byte ignored; queue ACK then the current led value (value before any change); -> RSP0.
  - Other cmd: frm_err=1; queue NAK only; -> RSP0.
- RSP0:
  - tx_vld=1 with the first byte.
  - On tx_vld&&tx_rdy: -> RSP1 if two bytes are queued, else -> IDLE with tx_vld=0 next cycle.
- RSP1:
  - tx_vld=1 with the second byte.
  - On tx_vld&&tx_rdy: -> IDLE, tx_vld=0.
- Handshake rules:
  - tx_data must stay stable while tx_vld=1 and tx_rdy=0.
  - tx_vld never drops without acceptance.
  - Minimum one-cycle tx_vld=0 gap after the last response byte.
- Frame latency: EXEC is the cycle after the chk byte's rx_vld; tx_vld rises the cycle after EXEC (2 cycles after the chk strobe).
- Bytes during EXEC/RSP0/RSP1: rx_vld is ignored (byte dropped, no frm_err).
- HEAD byte received in GET_CMD/GET_DAT/GET_CHK: treated as ordinary payload; no resync.
- led changes only via a valid write command; it holds through timeouts, NAKs and checksum errors.
- frm_err is high for exactly one cycle per dropped frame.
- Reset asserted mid-frame or mid-response: immediate return to reset values; any pending response is abandoned.

Test Plan:
- Write frame 55 01 3C 3D, tx_rdy=1 -> led=8'h3C one cycle after EXEC; tx bytes AA then 3C; frm_err stays 0.
- After led=3C, send read 55 02 00 02 -> tx AA then 3C; led unchanged.
- Bad checksum 55 01 F0 00 -> frm_err pulses once the cycle after chk; no tx_vld; led keeps its prior value.
- Unknown cmd 55 07 11 16 -> frm_err pulse; single tx byte EE; led unchanged.
- Send 55 01, then silence for TIMEOUT cycles -> frm_err pulse, state IDLE. A following full write 55 01 81 80 works: led=81, tx AA 81.
- Backpressure: tx_rdy=0 for 50 cycles during a write response -> tx_vld=1 and tx_data=AA stable throughout. Bytes received meanwhile are ignored. On tx_rdy=1, AA then 3C transfer in consecutive accepted cycles.
